// File: rtl/uart_pkg.sv
// Types and constants used by both UART directions.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    PARITY_BIT,
    STOP_BIT,
    BREAK
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/uart_rx_if.sv
// Receiver bus: oversample tick and serial line in, byte and error flags out.
interface uart_rx_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  baud_tick_os;
  logic                  rx_serial;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  parity_err;
  logic                  frame_err;

  // master drives the line and consumes bytes; slave is the receiver itself
  modport master (
    output baud_tick_os,
    output rx_serial,
    input  data_out,
    input  data_valid,
    input  parity_err,
    input  frame_err
  );

  modport slave (
    input  baud_tick_os,
    input  rx_serial,
    output data_out,
    output data_valid,
    output parity_err,
    output frame_err
  );

endinterface : uart_rx_if

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchronizer with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start, LSB-first data, even parity, stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.slave  bus_if
);

  localparam int unsigned OSW = $clog2(OVERSAMPLE);
  localparam int unsigned BCW = $clog2(DATA_WIDTH) + 1;
  localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

  uart_state_e           state_q;
  logic [OSW-1:0]        os_cnt_q;
  logic [BCW-1:0]        bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  par_bit_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  perr_q;
  logic                  ferr_q;

  logic tick;
  logic rx;

  assign tick = bus_if.baud_tick_os;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus_if.rx_serial),
    .q_o (rx)
  );

  // Start bit is qualified at its midpoint; later bits are sampled one full period apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (tick) begin
        os_cnt_q <= (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OSW'(1);
        case (state_q)
          IDLE: begin
            if (!rx) begin
              state_q  <= START_BIT;
              os_cnt_q <= '0;
            end
          end
          START_BIT: begin
            if (os_cnt_q == OS_MID) begin
              if (rx) begin
                state_q <= IDLE;
              end else begin
                state_q   <= DATA_BITS;
                os_cnt_q  <= '0;
                bit_cnt_q <= '0;
              end
            end
          end
          DATA_BITS: begin
            if (os_cnt_q == OS_LAST) begin
              shift_q   <= {rx, shift_q[DATA_WIDTH-1:1]};
              bit_cnt_q <= bit_cnt_q + BCW'(1);
              if (bit_cnt_q == BIT_LAST) begin
                state_q <= PARITY_BIT;
              end
            end
          end
          PARITY_BIT: begin
            if (os_cnt_q == OS_LAST) begin
              par_bit_q <= rx;
              state_q   <= STOP_BIT;
            end
          end
          STOP_BIT: begin
            if (os_cnt_q == OS_LAST) begin
              data_q  <= shift_q;
              perr_q  <= par_bit_q ^ (^shift_q);
              ferr_q  <= ~rx;
              valid_q <= 1'b1;
              state_q <= rx ? IDLE : BREAK;
            end
          end
          BREAK: begin
            // a held-low line must return high before a new start is accepted
            if (rx) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus_if.data_out   = data_q;
  assign bus_if.data_valid = valid_q;
  assign bus_if.parity_err = perr_q;
  assign bus_if.frame_err  = ferr_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames plus a short random burst.
module tb_uart_rx;
  import uart_pkg::*;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  logic clk;
  logic rst;
  int   tick_div;
  int   tcnt;
  int   vectors;
  int   miscompares;
  logic prev_dv;
  exp_t sb[$];

  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(
    .DATA_WIDTH (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // oversample tick: one clk wide every tick_div clks, or held high when tick_div <= 1
  always @(negedge clk) begin
    if (tick_div <= 1) begin
      bus.baud_tick_os = 1'b1;
    end else begin
      bus.baud_tick_os = (tcnt == 0);
      tcnt = (tcnt + 1) % tick_div;
    end
  end

  // monitor: every strobe must match the next expected frame and be one clk wide
  always @(negedge clk) begin
    if (bus.data_valid) begin
      vectors++;
      if (prev_dv) begin
        miscompares++;
        $display("FAIL dv_width: data_valid high on consecutive clks, required one-clk pulse");
      end else if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: data_out=%02h pe=%0b fe=%0b, required no strobe",
                 bus.data_out, bus.parity_err, bus.frame_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.data_out !== e.d || bus.parity_err !== e.pe || bus.frame_err !== e.fe) begin
          miscompares++;
          $display("FAIL frame: got data=%02h pe=%0b fe=%0b, required data=%02h pe=%0b fe=%0b",
                   bus.data_out, bus.parity_err, bus.frame_err, e.d, e.pe, e.fe);
        end
      end
    end
    prev_dv = bus.data_valid;
  end

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (bus.baud_tick_os) k++;
    end
  endtask

  task automatic drive(input logic v, input int n);
    @(negedge clk);
    bus.rx_serial = v;
    wait_ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_v);
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) drive(d[i], 16);
    drive((^d) ^ par_flip, 16);
    drive(stop_v, 16);
  endtask

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.d  = d;
    e.pe = pe;
    e.fe = fe;
    sb.push_back(e);
  endtask

  task automatic expect_drained(input string name);
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected frame(s) never delivered, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_outputs(input string name, input logic [7:0] d, input logic pe,
                               input logic fe, input logic dv);
    vectors++;
    if (bus.data_out !== d || bus.parity_err !== pe || bus.frame_err !== fe ||
        bus.data_valid !== dv) begin
      miscompares++;
      $display("FAIL %s: got data=%02h pe=%0b fe=%0b dv=%0b, required data=%02h pe=%0b fe=%0b dv=%0b",
               name, bus.data_out, bus.parity_err, bus.frame_err, bus.data_valid, d, pe, fe, dv);
    end
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (dut.state_q !== IDLE) begin
      miscompares++;
      $display("FAIL %s: state=%0d, required IDLE", name, dut.state_q);
    end
  endtask

  initial begin
    logic [7:0] rb;
    vectors     = 0;
    miscompares = 0;
    prev_dv     = 1'b0;
    tick_div    = 4;
    tcnt        = 0;
    bus.baud_tick_os = 1'b0;
    bus.rx_serial    = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs("reset_state", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 20);
    check_idle("idle_after_reset");

    push(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b0, 1'b1);
    drive(1'b1, 8);
    expect_drained("a5_frame");

    push(8'h07, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1);
    drive(1'b1, 8);
    expect_drained("07_parity");

    push(8'h3C, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b0);
    drive(1'b0, 40);
    expect_drained("3c_framing");
    check_outputs("break_hold", 8'h3C, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 20);
    push(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b1);
    drive(1'b1, 8);
    expect_drained("55_after_break");

    drive(1'b0, 4);
    drive(1'b1, 40);
    check_idle("glitch_idle");
    check_outputs("glitch_hold", 8'h55, 1'b0, 1'b0, 1'b0);

    drive(1'b0, 16);
    for (int i = 0; i < 3; i++) drive(1'b1, 16);
    drive(1'b1, 8);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs("midframe_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive(1'b1, 30);
    check_idle("idle_after_abort");
    push(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1);
    drive(1'b1, 8);
    expect_drained("81_after_reset");

    tick_div = 1;
    push(8'h5A, 1'b0, 1'b0);
    drive(1'b1, 10);
    send_frame(8'h5A, 1'b0, 1'b1);
    drive(1'b1, 8);
    expect_drained("5a_tick_high");
    tick_div = 4;

    for (int n = 0; n < 8; n++) begin
      rb = 8'($urandom_range(0, 255));
      push(rb, 1'b0, 1'b0);
      send_frame(rb, 1'b0, 1'b1);
    end
    drive(1'b1, 8);
    expect_drained("random_burst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver that consumes the line driven by the team's UART transmitter.
- Frame format: 1 start bit (0), DATA_WIDTH data bits LSB first, 1 even-parity bit (XOR of the data bits), 1 stop bit (1).
- Samples the line with a 16x oversampling tick and re-assembles the byte.
- Presents each received byte with a one-cycle valid strobe, plus parity and framing error flags.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
OVERSAMPLE, 16, baud_tick_os pulses per bit period; must be even and >= 4

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
baud_tick_os  input  1  one-clk pulse at OVERSAMPLE x baud rate; all sampling advances only on this pulse
rx_serial  input  1  asynchronous serial line, idle high
data_out  output  DATA_WIDTH  last received byte; held until the next frame completes
data_valid  output  1  one-clk pulse: frame complete, data_out and error flags updated
parity_err  output  1  received parity != XOR of data_out; valid with data_valid, held until the next frame
frame_err  output  1  stop bit sampled as 0; valid with data_valid, held until the next frame

Behaviour:
- Reset (async, active-high): state=IDLE, both synchronizer flops=1, os_cnt=0, bit_cnt=0, shift_reg=0, data_out=0, data_valid=0, parity_err=0, frame_err=0.
- rx_serial passes through a 2-flop synchronizer (free-running on clk, not gated by the tick). "rx" below means the synchronized value.
- os_cnt: $clog2(OVERSAMPLE) bits. It increments on each baud_tick_os and wraps from OVERSAMPLE-1 to 0. MID = OVERSAMPLE/2-1.
- All state and counter updates occur only on clk edges with baud_tick_os=1. The exception is data_valid, which deasserts on the next clk regardless of the tick.
- State machine:
  - IDLE: on a tick with rx=0 -> START, os_cnt=0.
  - START: on a tick with os_cnt==MID, sample rx.
    - rx=1: glitch -> IDLE. No data_valid.
    - rx=0: -> DATA, os_cnt=0, bit_cnt=0.
  - DATA: on a tick with os_cnt==OVERSAMPLE-1 (mid-bit), shift rx into shift_reg MSB and shift right, so the first bit received lands in bit 0 after DATA_WIDTH shifts. bit_cnt++. When bit_cnt==DATA_WIDTH-1 on this sample -> PARITY.
  - PARITY: on a tick with os_cnt==OVERSAMPLE-1, latch rx into par_bit -> STOP.
  - STOP: on a tick with os_cnt==OVERSAMPLE-1:
    - data_out<=shift_reg, parity_err<=par_bit^(^shift_reg), frame_err<=~rx, data_valid<=1.
    - Next state: IDLE if rx=1, BREAK if rx=0.
  - BREAK: wait for a tick with rx=1 -> IDLE. Prevents a held-low line (break) from being re-read as start bits.
- Latency: data_valid rises on the clk edge of the stop-bit mid-sample tick. That is roughly 0.5 bit period plus 2 clk (synchronizer) after the stop bit begins.
- data_valid is exactly one clk wide, even if baud_tick_os is held high continuously.
- Frames with errors are still delivered: data_valid=1 with the flag(s) set, and data_out is updated.
- Back-to-back frames: a start edge in the same tick that STOP->IDLE occurs is detected on the next tick. Phase loss is <= 1 tick, which is acceptable.
- Reset mid-frame: all state is discarded immediately. No data_valid for the partial frame.
- bit_cnt width: $clog2(DATA_WIDTH)+1.

Decomposition:
- uart_pkg: shared typedef enum for states (IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT, BREAK) and constant UART_OVERSAMPLE=16. uart_tx and uart_rx both import it.
- Sub-module sync_2ff: a generic 2-flop synchronizer with parameterised reset value (1 here). It is instantiated once, on rx_serial.

Test Plan:
- Byte 0xA5: drive idle, start, bits 1,0,1,0,0,1,0,1, parity 0, stop 1, each 16 ticks -> one data_valid pulse, data_out=0xA5, parity_err=0, frame_err=0.
- Byte 0x07 with parity bit driven 0 (correct is 1) -> data_out=0x07, parity_err=1, frame_err=0.
- Byte 0x3C with stop bit driven 0, line held low 40 ticks, then high, then a valid 0x55 frame:
  - first frame -> data_out=0x3C, frame_err=1, and no further valid strobes while the line stays low;
  - then data_out=0x55 with both flags 0.
- Glitch: line low for 4 ticks, then high for 40 ticks -> no data_valid, state back to IDLE.
- Reset asserted during data bit 3 of 0xFF, released, then a clean 0x81 frame -> exactly one data_valid, data_out=0x81, no strobe from the aborted frame.
- Loopback: uart_tx -> uart_rx sharing the clock, 256 random bytes with tx ticks at 1/16 of the rx tick rate -> every byte received in order, zero error flags.
